// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: record/playback sequencer for the note memory.
// Recording writes one note per beat tick. Playback reads one slot per tick
// and presents each returned word on note_out with a one-cycle note_valid.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no activity; accepts rec_start / play_start
//   RECORD | one memory write per beat_tick; leaves when the memory is full
//   PLAY   | one memory read per beat_tick; wraps or drains after last slot
//   DRAIN  | last read is still in flight; returns to IDLE once captured
module note_seq_ctrl #(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          beat_tick_i,
    input  logic          rec_start_i,
    input  logic          play_start_i,
    input  logic          stop_i,
    input  logic          loop_en_i,
    input  logic [DW-1:0] note_in_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_wren_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [DW-1:0] note_out_o,
    output logic          note_valid_o,
    output logic [AW:0]   rec_len_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LEN_LAST = (AW+1)'(DEPTH - 1);

    state_t          state_q,      state_d;
    logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [AW:0]     rec_len_q,    rec_len_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic            mem_wren_q,   mem_wren_d;
    logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [DW-1:0]   note_out_q,   note_out_d;
    logic            note_valid_q, note_valid_d;
    // one bit per clock of read latency; the top bit marks the capture edge
    logic [RD_LAT:0] pend_q,       pend_d;

    logic capture;
    logic last_slot;

    assign capture   = pend_q[RD_LAT];
    assign last_slot = ({1'b0, rd_ptr_q} == (rec_len_q - LEN_ONE));

    // Next-state and output decode: stop beats starts, starts beat ticks.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rec_len_d    = rec_len_q;
        mem_addr_d   = mem_addr_q;
        mem_wren_d   = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        note_out_d   = note_out_q;
        note_valid_d = 1'b0;
        pend_d       = pend_q << 1;

        if (capture) begin
            note_out_d   = mem_rdata_i;
            note_valid_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (rec_start_i) begin
                    state_d   = S_RECORD;
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                end else if (play_start_i && (rec_len_q != '0)) begin
                    state_d    = S_PLAY;
                    rd_ptr_d   = '0;
                    note_out_d = '0;
                end
            end
            S_RECORD: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (beat_tick_i) begin
                    mem_wren_d  = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = note_in_i;
                    wr_ptr_d    = wr_ptr_q + PTR_ONE;
                    rec_len_d   = rec_len_q + LEN_ONE;
                    if (rec_len_q == LEN_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                if (stop_i) begin
                    state_d      = S_IDLE;
                    pend_d       = '0;
                    note_out_d   = '0;
                    note_valid_d = 1'b0;
                end else if (beat_tick_i) begin
                    mem_addr_d = rd_ptr_q;
                    pend_d[0]  = 1'b1;
                    if (last_slot) begin
                        rd_ptr_d = '0;
                        if (!loop_en_i) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (stop_i) begin
                    state_d      = S_IDLE;
                    pend_d       = '0;
                    note_out_d   = '0;
                    note_valid_d = 1'b0;
                end else if (capture) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rec_len_q    <= '0;
            mem_addr_q   <= '0;
            mem_wren_q   <= 1'b0;
            mem_wdata_q  <= '0;
            note_out_q   <= '0;
            note_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rec_len_q    <= rec_len_d;
            mem_addr_q   <= mem_addr_d;
            mem_wren_q   <= mem_wren_d;
            mem_wdata_q  <= mem_wdata_d;
            note_out_q   <= note_out_d;
            note_valid_q <= note_valid_d;
            pend_q       <= pend_d;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_wren_o   = mem_wren_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign note_out_o   = note_out_q;
    assign note_valid_o = note_valid_q;
    assign rec_len_o    = rec_len_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Testbench for note_seq_ctrl: directed stimulus, a RAM with one clock of
// read latency, a cycle-level reference model and literal spot checks.
module tb_note_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        beat_tick, rec_start, play_start, stop, loop_en;
    logic [31:0] note_in;
    logic [31:0] mem_rdata = '0;
    logic [5:0]  mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] note_out;
    logic        note_valid;
    logic [6:0]  rec_len;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    note_seq_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .beat_tick_i  (beat_tick),
        .rec_start_i  (rec_start),
        .play_start_i (play_start),
        .stop_i       (stop),
        .loop_en_i    (loop_en),
        .note_in_i    (note_in),
        .mem_rdata_i  (mem_rdata),
        .mem_addr_o   (mem_addr),
        .mem_wren_o   (mem_wren),
        .mem_wdata_o  (mem_wdata),
        .note_out_o   (note_out),
        .note_valid_o (note_valid),
        .rec_len_o    (rec_len),
        .state_o      (state)
    );

    always #10 clk = ~clk;

    // RAM: synchronous write, registered read (one clock of latency)
    logic [31:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 record, 2 play, 3 drain. Each read is a queue entry
    // holding the cycle number on which its data must reach note_out.
    typedef struct { int due; logic [31:0] d; } pend_t;
    pend_t       pq[$];
    logic [31:0] exp_mem [64];
    int          cyc = 0, m_state = 0, m_wr = 0, m_rd = 0, m_len = 0, prev;
    bit          started = 0;
    logic [31:0] e_addr, e_wdata, e_note;
    logic        e_wren, e_valid;

    initial for (int i = 0; i < 64; i++) exp_mem[i] = '0;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!resetn) begin
            m_state = 0; m_wr = 0; m_rd = 0; m_len = 0;
            e_addr = 0; e_wdata = 0; e_note = 0; e_wren = 0; e_valid = 0;
            pq.delete();
        end else begin
            e_wren  = 0;
            e_valid = 0;
            prev    = m_state;
            if (stop) begin
                if (prev >= 2) begin
                    pq.delete();
                    e_note = 0;
                end
                m_state = 0;
            end else begin
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    e_note  = pq[0].d;
                    e_valid = 1;
                    void'(pq.pop_front());
                    if (prev == 3) m_state = 0;
                end
                case (prev)
                    0: if (rec_start) begin
                           m_state = 1; m_wr = 0; m_len = 0;
                       end else if (play_start && m_len > 0) begin
                           m_state = 2; m_rd = 0; e_note = 0;
                       end
                    1: if (beat_tick) begin
                           e_wren = 1; e_addr = m_wr; e_wdata = note_in;
                           exp_mem[m_wr] = note_in;
                           m_wr = (m_wr + 1) % 64;
                           m_len++;
                           if (m_len == 64) m_state = 0;
                       end
                    2: if (beat_tick) begin
                           e_addr = m_rd;
                           pq.push_back('{cyc + 2, exp_mem[m_rd]});
                           if (m_rd == m_len - 1) begin
                               m_rd = 0;
                               if (!loop_en) m_state = 3;
                           end else m_rd++;
                       end
                    default: ;
                endcase
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (started) begin
            chk("m_state",      {30'd0, state},    m_state);
            chk("m_rec_len",    {25'd0, rec_len},  m_len);
            chk("m_mem_addr",   {26'd0, mem_addr}, e_addr);
            chk("m_mem_wren",   {31'd0, mem_wren}, {31'd0, e_wren});
            chk("m_note_valid", {31'd0, note_valid}, {31'd0, e_valid});
            chk("m_note_out",   note_out, e_note);
            if (e_wren) chk("m_mem_wdata", mem_wdata, e_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_tick();
        beat_tick = 1'b1;
        @(negedge clk);
        beat_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] t1 [3];
    logic [31:0] t6 [3];
    logic [5:0]  loop_addr [7];
    logic [31:0] last_note;

    initial begin
        t1 = '{32'h1, 32'h40, 32'h1000};
        t6 = '{32'hA5, 32'h5A0, 32'h8000_0001};
        loop_addr = '{6'd0, 6'd1, 6'd2, 6'd0, 6'd1, 6'd2, 6'd0};
        resetn = 0; beat_tick = 0; rec_start = 0; play_start = 0;
        stop = 0; loop_en = 0; note_in = 0;
        idle(2);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_rec_len", {25'd0, rec_len}, 0);
        chk("rst_wren", {31'd0, mem_wren}, 0);
        chk("rst_note_out", note_out, 0);
        chk("rst_note_valid", {31'd0, note_valid}, 0);
        resetn = 1;
        idle(1);

        // record three notes
        rec_start = 1; @(negedge clk); rec_start = 0;
        for (int i = 0; i < 3; i++) begin
            note_in = t1[i];
            pulse_tick();
            chk("rec_wren", {31'd0, mem_wren}, 1);
            chk("rec_addr", {26'd0, mem_addr}, i);
            chk("rec_wdata", mem_wdata, t1[i]);
            idle(3);
        end
        chk("rec_len3", {25'd0, rec_len}, 3);
        chk("rec_state", {30'd0, state}, 1);

        // stop, then play back without looping
        stop = 1; @(negedge clk); stop = 0;
        chk("stop_idle", {30'd0, state}, 0);
        chk("stop_len_kept", {25'd0, rec_len}, 3);
        play_start = 1; @(negedge clk); play_start = 0;
        chk("play_state", {30'd0, state}, 2);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            if (i == 2) chk("drain_state", {30'd0, state}, 3);
            idle(2);
            chk("play_valid", {31'd0, note_valid}, 1);
            chk("play_note", note_out, t1[i]);
            if (i == 2) chk("drain_done", {30'd0, state}, 0);
        end
        idle(2);
        chk("hold_note", note_out, 32'h1000);

        // looping playback
        loop_en = 1;
        play_start = 1; @(negedge clk); play_start = 0;
        for (int i = 0; i < 7; i++) begin
            pulse_tick();
            chk("loop_addr", {26'd0, mem_addr}, {26'd0, loop_addr[i]});
            chk("loop_state", {30'd0, state}, 2);
            idle(3);
        end
        stop = 1; @(negedge clk); stop = 0;
        loop_en = 0;
        chk("loop_stop_note", note_out, 0);

        // fill all 64 slots, then try one more
        rec_start = 1; @(negedge clk); rec_start = 0;
        for (int i = 0; i < 64; i++) begin
            note_in = (32'h1 << (i % 32)) ^ i;
            pulse_tick();
            idle(2);
        end
        chk("full_len", {25'd0, rec_len}, 64);
        chk("full_idle", {30'd0, state}, 0);
        note_in = 32'hDEAD;
        pulse_tick();
        chk("full_no_wren", {31'd0, mem_wren}, 0);
        idle(2);
        play_start = 1; @(negedge clk); play_start = 0;
        for (int i = 0; i < 64; i++) begin
            pulse_tick();
            idle(2);
        end
        idle(2);
        last_note = (32'h1 << 31) ^ 32'd63;
        chk("full_play_state", {30'd0, state}, 0);
        chk("full_last_note", note_out, last_note);

        // start corner cases
        resetn = 0; @(negedge clk); resetn = 1;
        chk("rst2_len", {25'd0, rec_len}, 0);
        play_start = 1; @(negedge clk); play_start = 0;
        chk("play_empty", {30'd0, state}, 0);
        stop = 1; rec_start = 1; @(negedge clk); stop = 0; rec_start = 0;
        chk("stop_beats_start", {30'd0, state}, 0);
        rec_start = 1; play_start = 1; @(negedge clk); rec_start = 0; play_start = 0;
        chk("rec_wins", {30'd0, state}, 1);

        // stop coinciding with a tick, and stop with a read in flight
        for (int i = 0; i < 3; i++) begin
            note_in = t6[i];
            pulse_tick();
            idle(2);
        end
        stop = 1; @(negedge clk); stop = 0;
        play_start = 1; @(negedge clk); play_start = 0;
        pulse_tick();
        idle(3);
        chk("t6_first", note_out, t6[0]);
        stop = 1; beat_tick = 1; @(negedge clk); stop = 0; beat_tick = 0;
        chk("stop_tick_state", {30'd0, state}, 0);
        chk("stop_tick_note", note_out, 0);
        idle(3);
        chk("stop_tick_novalid", {31'd0, note_valid}, 0);
        play_start = 1; @(negedge clk); play_start = 0;
        pulse_tick();
        stop = 1; @(negedge clk); stop = 0;
        idle(2);
        chk("discard_valid", {31'd0, note_valid}, 0);
        chk("discard_note", note_out, 0);

        // reset in the middle of recording
        rec_start = 1; @(negedge clk); rec_start = 0;
        for (int i = 0; i < 2; i++) begin
            note_in = 32'h77 + i;
            pulse_tick();
            idle(2);
        end
        chk("mid_len2", {25'd0, rec_len}, 2);
        resetn = 0; @(negedge clk); resetn = 1;
        chk("mid_rst_len", {25'd0, rec_len}, 0);
        chk("mid_rst_state", {30'd0, state}, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
